// File: rtl/mouse_pos_ctl.sv
// Mouse position conditioner: clamps the pointer to the screen and debounces buttons into click pulses.
// Optional build macro MOUSE_FRAME_LOCK_EN holds the position stable until the next vblnk rise.
module mouse_pos_ctl #(
    parameter int H_MAX           = 1023,
    parameter int V_MAX           = 767,
    parameter int DEBOUNCE_CYCLES = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    input  logic        mouse_right,
    input  logic        vblnk,
    output logic [11:0] mouse_x_pos,
    output logic [11:0] mouse_y_pos,
    output logic        left_click,
    output logic        right_click,
    output logic [11:0] click_x,
    output logic [11:0] click_y
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [11:0]       X_LIM    = 12'(H_MAX);
    localparam logic [11:0]       Y_LIM    = 12'(V_MAX);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_e;

    logic [11:0] cx, cy;
    logic [1:0]  btn_raw;

    logic [1:0]       sync0_q, sync0_d;
    logic [1:0]       sync1_q, sync1_d;
    db_state_e        state_q [2];
    db_state_e        state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       click_q, click_d;
    logic [11:0]      pos_x_q, pos_x_d;
    logic [11:0]      pos_y_q, pos_y_d;
    logic [11:0]      click_x_q, click_x_d;
    logic [11:0]      click_y_q, click_y_d;

    assign btn_raw = {mouse_right, mouse_left};

    always_comb begin
        cx = (mouse_xpos > X_LIM) ? X_LIM : mouse_xpos;
        cy = (mouse_ypos > Y_LIM) ? Y_LIM : mouse_ypos;
    end

    // Index 0 is the left button, index 1 the right; both share one FSM description.
    always_comb begin
        sync0_d = btn_raw;
        sync1_d = sync0_q;
        click_d = 2'b00;
        for (int b = 0; b < 2; b++) begin
            // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            case (state_q[b])
                IDLE: begin
                    if (sync1_q[b]) begin
                        state_d[b] = PRESS_WAIT;
                        cnt_d[b]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync1_q[b]) begin
                        state_d[b] = IDLE;
                    end else if (cnt_q[b] == CNT_LAST) begin
                        state_d[b] = HELD;
                        click_d[b] = 1'b1;
                    end else begin
                        cnt_d[b] = cnt_q[b] + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!sync1_q[b]) begin
                        state_d[b] = RELEASE_WAIT;
                        cnt_d[b]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (sync1_q[b]) begin
                        state_d[b] = HELD;
                    end else if (cnt_q[b] == CNT_LAST) begin
                        state_d[b] = IDLE;
                    end else begin
                        cnt_d[b] = cnt_q[b] + CNT_W'(1);
                    end
                end
                default: state_d[b] = IDLE;
            endcase
        end
        click_x_d = (|click_d) ? cx : click_x_q;
        click_y_d = (|click_d) ? cy : click_y_q;
    end

`ifdef MOUSE_FRAME_LOCK_EN
    // vblnk_prev_q is the registered vblnk (vblnk_d); position loads only on its rising edge.
    logic vblnk_prev_q, vblnk_prev_d;
    logic frame_edge;

    always_comb begin
        vblnk_prev_d = vblnk;
        frame_edge   = vblnk & ~vblnk_prev_q;
        pos_x_d      = frame_edge ? cx : pos_x_q;
        pos_y_d      = frame_edge ? cy : pos_y_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vblnk_prev_q <= 1'b0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
        end
    end
`else
    logic unused_vblnk;
    assign unused_vblnk = vblnk;

    always_comb begin
        pos_x_d = cx;
        pos_y_d = cy;
    end
`endif

    // NOTE: state uses non-blocking assignments only; reset is synchronous and sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync0_q   <= 2'b00;
            sync1_q   <= 2'b00;
            click_q   <= 2'b00;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            click_x_q <= '0;
            click_y_q <= '0;
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= IDLE;
                cnt_q[b]   <= '0;
            end
        end else begin
            sync0_q   <= sync0_d;
            sync1_q   <= sync1_d;
            click_q   <= click_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            click_x_q <= click_x_d;
            click_y_q <= click_y_d;
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
        end
    end

    assign mouse_x_pos = pos_x_q;
    assign mouse_y_pos = pos_y_q;
    assign left_click  = click_q[0];
    assign right_click = click_q[1];
    assign click_x     = click_x_q;
    assign click_y     = click_y_q;

endmodule

// File: tb/tb_mouse_pos_ctl.sv
// Self-checking bench for mouse_pos_ctl: run-length debounce model compared every cycle, plus directed literal checks.
// Works in both builds (MOUSE_FRAME_LOCK_EN defined or not).
module tb_mouse_pos_ctl;

    localparam int DC    = 4;
    localparam int H_MAX = 1023;
    localparam int V_MAX = 767;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] mouse_xpos, mouse_ypos;
    logic        mouse_left, mouse_right, vblnk;
    logic [11:0] mouse_x_pos, mouse_y_pos, click_x, click_y;
    logic        left_click, right_click;

    always #5 clk = ~clk;

    mouse_pos_ctl #(
        .H_MAX(H_MAX),
        .V_MAX(V_MAX),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mouse_xpos(mouse_xpos),
        .mouse_ypos(mouse_ypos),
        .mouse_left(mouse_left),
        .mouse_right(mouse_right),
        .vblnk(vblnk),
        .mouse_x_pos(mouse_x_pos),
        .mouse_y_pos(mouse_y_pos),
        .left_click(left_click),
        .right_click(right_click),
        .click_x(click_x),
        .click_y(click_y)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    // Model: a button flips its accepted level after DC+1 consecutive synchronized
    // samples that disagree with it; a flip to pressed is a click.
    bit m_en = 1'b0;
    int m_x, m_y, m_cx, m_cy;
    bit m_lc, m_rc;
    bit dly1 [2];
    bit dly2 [2];
    bit lvl  [2];
    int run  [2];
    bit vb_prev;

    always @(posedge clk) begin
        bit raw   [2];
        bit pulse [2];
        bit bs;
        raw[0] = mouse_left;
        raw[1] = mouse_right;
        if (!rst) begin
            m_en = 1'b1;
            m_x = 0; m_y = 0; m_cx = 0; m_cy = 0;
            m_lc = 1'b0; m_rc = 1'b0; vb_prev = 1'b0;
            for (int b = 0; b < 2; b++) begin
                dly1[b] = 1'b0; dly2[b] = 1'b0; lvl[b] = 1'b0; run[b] = 0;
            end
        end else if (m_en) begin
            for (int b = 0; b < 2; b++) begin
                bs       = dly2[b];
                dly2[b]  = dly1[b];
                dly1[b]  = raw[b];
                pulse[b] = 1'b0;
                if (bs != lvl[b]) begin
                    run[b]++;
                    if (run[b] == DC + 1) begin
                        lvl[b]   = bs;
                        run[b]   = 0;
                        pulse[b] = bs;
                    end
                end else begin
                    run[b] = 0;
                end
            end
            m_lc = pulse[0];
            m_rc = pulse[1];
            if (pulse[0] || pulse[1]) begin
                m_cx = clampv(int'(mouse_xpos), H_MAX);
                m_cy = clampv(int'(mouse_ypos), V_MAX);
            end
`ifdef MOUSE_FRAME_LOCK_EN
            if (vblnk && !vb_prev) begin
                m_x = clampv(int'(mouse_xpos), H_MAX);
                m_y = clampv(int'(mouse_ypos), V_MAX);
            end
            vb_prev = vblnk;
`else
            m_x = clampv(int'(mouse_xpos), H_MAX);
            m_y = clampv(int'(mouse_ypos), V_MAX);
`endif
        end
    end

    always @(negedge clk) begin
        if (m_en) begin
            check("model mouse_x_pos", mouse_x_pos, m_x);
            check("model mouse_y_pos", mouse_y_pos, m_y);
            check("model left_click", left_click, m_lc);
            check("model right_click", right_click, m_rc);
            check("model click_x", click_x, m_cx);
            check("model click_y", click_y, m_cy);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Steps until any click is seen (bounded); lat = edges taken, -1 if none.
    task automatic wait_click(output int lat, output bit l, output bit r);
        lat = -1; l = 1'b0; r = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (left_click || right_click) begin
                lat = k; l = left_click; r = right_click;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        bit l, r;
        int pulses;
        logic [7:0] pat;

        rst = 1'b0; mouse_xpos = '0; mouse_ypos = '0;
        mouse_left = 1'b0; mouse_right = 1'b0; vblnk = 1'b0;
        step(3);
        check("reset mouse_x_pos", mouse_x_pos, 0);
        check("reset left_click", left_click, 0);
        check("reset click_x", click_x, 0);
        rst = 1'b1;

        // Clamp of out-of-range coordinates
        mouse_xpos = 12'd2000; mouse_ypos = 12'd900;
`ifdef MOUSE_FRAME_LOCK_EN
        vblnk = 1'b1;
        step(1);
        vblnk = 1'b0;
`else
        step(1);
`endif
        check("clamp x", mouse_x_pos, 1023);
        check("clamp y", mouse_y_pos, 767);

        // Steady press: one pulse at edge DC+3, none while held
        mouse_xpos = 12'd300; mouse_ypos = 12'd200;
        mouse_left = 1'b1;
        wait_click(lat, l, r);
        check("press latency", lat, 7);
        check("press left only", {l, r}, 2'b10);
        check("press click_x", click_x, 300);
        check("press click_y", click_y, 200);
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            step(1);
            pulses += int'(left_click);
        end
        check("held repeat pulses", pulses, 0);
        mouse_left = 1'b0;
        step(10);

        // Bounce 1-0-1-0 of 2 cycles each, then low
        pat = 8'b0011_0011;
        pulses = 0;
        for (int k = 0; k < 24; k++) begin
            mouse_left = (k < 8) ? pat[k] : 1'b0;
            step(1);
            pulses += int'(left_click);
        end
        check("bounce pulses", pulses, 0);
        mouse_left = 1'b1;
        wait_click(lat, l, r);
        check("post-bounce latency", lat, 7);
        mouse_left = 1'b0;
        step(10);

        // Simultaneous left and right
        mouse_xpos = 12'd10; mouse_ypos = 12'd20;
        mouse_left = 1'b1; mouse_right = 1'b1;
        wait_click(lat, l, r);
        check("both latency", lat, 7);
        check("both pulse", {l, r}, 2'b11);
        check("both click_x", click_x, 10);
        check("both click_y", click_y, 20);
        mouse_left = 1'b0; mouse_right = 1'b0;
        step(10);

        // Reset during PRESS_WAIT discards the press
        mouse_left = 1'b1;
        step(4);
        rst = 1'b0;
        step(1);
        check("mid reset mouse_x_pos", mouse_x_pos, 0);
        check("mid reset mouse_y_pos", mouse_y_pos, 0);
        check("mid reset click_x", click_x, 0);
        check("mid reset click_y", click_y, 0);
        check("mid reset clicks", {left_click, right_click}, 2'b00);
        step(2);
        rst = 1'b1;
        wait_click(lat, l, r);
        check("post reset latency", lat, DC + 3);
        mouse_left = 1'b0;
        step(10);

        // Position update behaviour
        mouse_xpos = 12'd5; mouse_ypos = 12'd5;
`ifdef MOUSE_FRAME_LOCK_EN
        vblnk = 1'b1;
        step(1);
        vblnk = 1'b0;
        check("lock load x", mouse_x_pos, 5);
        mouse_xpos = 12'd600; mouse_ypos = 12'd400;
        step(5);
        check("lock hold x", mouse_x_pos, 5);
        check("lock hold y", mouse_y_pos, 5);
        vblnk = 1'b1;
        step(1);
        vblnk = 1'b0;
        check("lock update x", mouse_x_pos, 600);
        check("lock update y", mouse_y_pos, 400);
`else
        step(1);
        check("free x 5", mouse_x_pos, 5);
        mouse_xpos = 12'd600; mouse_ypos = 12'd400;
        vblnk = 1'b1;
        step(1);
        vblnk = 1'b0;
        check("free update x", mouse_x_pos, 600);
        check("free update y", mouse_y_pos, 400);
`endif
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
